// File: rtl/irq_request_gen.sv
// irq_request_gen: per-channel key-to-interrupt request generator.
// Three independent channels each synchronize and debounce a raw key,
// issue a fixed-width break pulse on a press, then track the interrupt
// controller's pending level through acknowledge and completion.
// Completed services from all channels are tallied in a shared 8-bit count.
module irq_request_gen #(
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned PULSE_W     = 2,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key,
    input  logic [2:0] iw,
    output logic [2:0] brk,
    output logic [2:0] busy,
    output logic [2:0] done,
    output logic [2:0] err,
    output logic [2:0] drop,
    output logic [7:0] cnt
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PULSE     = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE - 1);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
    localparam logic [7:0] ACK_LAST   = 8'(ACK_TIMEOUT - 1);

    // Synchronizers
    logic [2:0]      key_s1_q, key_s2_q;
    logic [2:0]      iw_s1_q, iw_s2_q;

    // Debounce state
    logic [2:0]      key_lvl_q, key_lvl_d;
    logic [2:0]      key_db_q, key_db_d;
    logic [2:0][7:0] db_cnt_q, db_cnt_d;
    logic [2:0]      press;

    // Channel FSMs and timers
    logic [2:0][1:0] state_q, state_d;
    logic [2:0][3:0] pcnt_q, pcnt_d;
    logic [2:0][7:0] tmr_q, tmr_d;

    // Registered outputs
    logic [2:0]      brk_q, brk_d;
    logic [2:0]      busy_q, busy_d;
    logic [2:0]      done_q, done_d;
    logic [2:0]      err_q, err_d;
    logic [2:0]      drop_q, drop_d;
    logic [7:0]      cnt_q, cnt_d;

    // Two-flop synchronizers for the asynchronous key and iw inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_s1_q <= '0;
            key_s2_q <= '0;
            iw_s1_q  <= '0;
            iw_s2_q  <= '0;
        end else begin
            key_s1_q <= key;
            key_s2_q <= key_s1_q;
            iw_s1_q  <= iw;
            iw_s2_q  <= iw_s1_q;
        end
    end

    // Debounce: restart the stability count on any change, adopt the level once it has held
    always_comb begin
        key_lvl_d = key_s2_q;
        key_db_d  = key_db_q;
        db_cnt_d  = db_cnt_q;
        for (int unsigned n = 0; n < 3; n++) begin
            if (key_s2_q[n] != key_lvl_q[n]) begin
                db_cnt_d[n] = '0;
            end else if (db_cnt_q[n] == DEB_LAST) begin
                key_db_d[n] = key_lvl_q[n];
            end else begin
                db_cnt_d[n] = db_cnt_q[n] + 8'd1;
            end
        end
        press = key_db_d & ~key_db_q;
    end

    // Per-channel request FSM, output pulses and shared completion count
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tmr_d   = tmr_q;
        done_d  = '0;
        err_d   = '0;
        drop_d  = '0;
        brk_d   = '0;
        busy_d  = '0;
        cnt_d   = cnt_q;
        for (int unsigned n = 0; n < 3; n++) begin
            drop_d[n] = press[n] && (state_q[n] != ST_IDLE);
            case (state_q[n])
                ST_IDLE: begin
                    if (press[n]) begin
                        state_d[n] = ST_PULSE;
                        pcnt_d[n]  = '0;
                    end
                end
                ST_PULSE: begin
                    if (pcnt_q[n] == PULSE_LAST) begin
                        state_d[n] = ST_WAIT_ACK;
                        tmr_d[n]   = '0;
                    end else begin
                        pcnt_d[n] = pcnt_q[n] + 4'd1;
                    end
                end
                ST_WAIT_ACK: begin
                    if (iw_s2_q[n]) begin
                        state_d[n] = ST_WAIT_DONE;
                    end else if (tmr_q[n] == ACK_LAST) begin
                        state_d[n] = ST_IDLE;
                        err_d[n]   = 1'b1;
                    end else begin
                        tmr_d[n] = tmr_q[n] + 8'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!iw_s2_q[n]) begin
                        state_d[n] = ST_IDLE;
                        done_d[n]  = 1'b1;
                    end
                end
                default: begin
                    state_d[n] = ST_IDLE;
                end
            endcase
            brk_d[n]  = (state_d[n] == ST_PULSE);
            busy_d[n] = (state_d[n] != ST_IDLE);
            if (done_d[n]) begin
                cnt_d = cnt_d + 8'd1;
            end
        end
    end

    // State, debounce and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_lvl_q <= '0;
            key_db_q  <= '0;
            db_cnt_q  <= '0;
            state_q   <= {3{ST_IDLE}};
            pcnt_q    <= '0;
            tmr_q     <= '0;
            brk_q     <= '0;
            busy_q    <= '0;
            done_q    <= '0;
            err_q     <= '0;
            drop_q    <= '0;
            cnt_q     <= '0;
        end else begin
            key_lvl_q <= key_lvl_d;
            key_db_q  <= key_db_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            tmr_q     <= tmr_d;
            brk_q     <= brk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
        end
    end

    assign brk  = brk_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign drop = drop_q;
    assign cnt  = cnt_q;

endmodule
